// File: rtl/writeback_unit_if.sv
// Writeback-stage bus: instruction presentation from the memory stage, load
// return data, and the register-file write port / retire count going back.
// master = memory stage side (drives instruction + load data), slave = writeback_unit.
interface writeback_unit_if #(
   parameter int ADDRESS_BITS = 20
);
   logic                    valid_in;
   logic [6:0]              opcode;
   logic [2:0]              funct3;
   logic [4:0]              rd;
   logic [31:0]             alu_result;
   logic [ADDRESS_BITS-1:0] PC;
   logic [31:0]             load_data;
   logic                    load_valid;
   logic                    busy;
   logic                    write;
   logic [4:0]              write_reg;
   logic [31:0]             write_data;
   logic [31:0]             retired;

   modport master (
      output valid_in, opcode, funct3, rd, alu_result, PC, load_data, load_valid,
      input  busy, write, write_reg, write_data, retired
   );

   modport slave (
      input  valid_in, opcode, funct3, rd, alu_result, PC, load_data, load_valid,
      output busy, write, write_reg, write_data, retired
   );
endinterface

// File: rtl/writeback_unit.sv
// Writeback stage: selects ALU / link / load result and drives the register-file write port.
// Latency: non-loads write and retire 1 cycle after acceptance; loads 1 cycle after load_valid.
// Backpressure: busy is high for the whole LOAD_WAIT state; upstream holds valid_in and fields.
// Ports: clock, reset (sync, active-high), report (enables trace), wb (slave modport:
//        instruction in, load data in, write/write_reg/write_data/retired/busy out).
module writeback_unit #(
   parameter int CORE         = 0,
   parameter int ADDRESS_BITS = 20
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            report,
   writeback_unit_if.slave wb
);
   localparam logic [6:0] OP_OP    = 7'b0110011;
   localparam logic [6:0] OP_IMM   = 7'b0010011;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;

   typedef enum logic {IDLE = 1'b0, LOAD_WAIT = 1'b1} state_t;

   state_t                  r_state;
   state_t                  w_next;

   // fields of the outstanding load, captured at acceptance
   logic [4:0]              r_ld_rd;
   logic [2:0]              r_ld_f3;
   logic [1:0]              r_ld_off;

   logic                    r_write;
   logic [4:0]              r_write_reg;
   logic [31:0]             r_write_data;
   logic [31:0]             r_retired;

   logic                    w_wr_en;
   logic [4:0]              w_wr_reg;
   logic [31:0]             w_wr_dat;
   logic                    w_retire;
   logic                    w_latch;
   logic                    w_ld_ok;
   logic [ADDRESS_BITS-1:0] w_pc4;
   logic [7:0]              w_byte;
   logic [15:0]             w_half;

   // link address wraps inside the PC width, then zero-extends
   assign w_pc4  = wb.PC + ADDRESS_BITS'(4);
   assign w_byte = wb.load_data[{r_ld_off, 3'b000} +: 8];
   assign w_half = r_ld_off[1] ? wb.load_data[31:16] : wb.load_data[15:0];

   always_comb begin
      w_next   = r_state;
      w_wr_en  = 1'b0;
      w_wr_reg = wb.rd;
      w_wr_dat = wb.alu_result;
      w_retire = 1'b0;
      w_latch  = 1'b0;
      w_ld_ok  = 1'b0;
      case (r_state)
         IDLE: begin
            if (wb.valid_in) begin
               case (wb.opcode)
                  OP_OP, OP_IMM, OP_LUI, OP_AUIPC: begin
                     w_wr_en  = (wb.rd != 5'd0);
                     w_retire = 1'b1;
                  end
                  OP_JAL, OP_JALR: begin
                     w_wr_en  = (wb.rd != 5'd0);
                     w_wr_dat = 32'(w_pc4);
                     w_retire = 1'b1;
                  end
                  OP_LOAD: begin
                     w_latch = 1'b1;
                     w_next  = LOAD_WAIT;
                  end
                  // stores, branches, fence, system, illegal: retire without a write
                  default: w_retire = 1'b1;
               endcase
            end
         end
         LOAD_WAIT: begin
            // valid_in is deliberately not looked at here; the held instruction
            // is taken once the state is back in IDLE
            if (wb.load_valid) begin
               w_next   = IDLE;
               w_retire = 1'b1;
               w_wr_reg = r_ld_rd;
               w_ld_ok  = 1'b1;
               case (r_ld_f3)
                  3'b000:  w_wr_dat = {{24{w_byte[7]}}, w_byte};
                  3'b001:  w_wr_dat = {{16{w_half[15]}}, w_half};
                  3'b010:  w_wr_dat = wb.load_data;
                  3'b100:  w_wr_dat = {24'd0, w_byte};
                  3'b101:  w_wr_dat = {16'd0, w_half};
                  default: begin
                     w_wr_dat = wb.load_data;
                     w_ld_ok  = 1'b0;
                  end
               endcase
               w_wr_en = w_ld_ok && (r_ld_rd != 5'd0);
            end
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state      <= IDLE;
         r_write      <= 1'b0;
         r_write_reg  <= 5'd0;
         r_write_data <= 32'd0;
         r_retired    <= 32'd0;
         r_ld_rd      <= 5'd0;
         r_ld_f3      <= 3'd0;
         r_ld_off     <= 2'd0;
      end else begin
         r_state <= w_next;
         r_write <= w_wr_en;
         // write_reg/write_data hold between pulses
         if (w_wr_en) begin
            r_write_reg  <= w_wr_reg;
            r_write_data <= w_wr_dat;
         end
         if (w_retire) begin
            r_retired <= r_retired + 32'd1;
         end
         if (w_latch) begin
            r_ld_rd  <= wb.rd;
            r_ld_f3  <= wb.funct3;
            r_ld_off <= wb.alu_result[1:0];
         end
      end
   end

   assign wb.busy       = (r_state == LOAD_WAIT);
   assign wb.write      = r_write;
   assign wb.write_reg  = r_write_reg;
   assign wb.write_data = r_write_data;
   assign wb.retired    = r_retired;

`ifndef SYNTHESIS
   always @(posedge clock) begin
      if (report) begin
         $display("core %0d state %s write %b write_reg %0d write_data %h retired %0d",
                  CORE, r_state.name(), r_write, r_write_reg, r_write_data, r_retired);
      end
   end
`endif
endmodule

// File: tb/tb_writeback_unit.sv
module tb_writeback_unit;
   localparam int AB = 20;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic report = 1'b0;

   int n_assert = 0;
   int n_fail   = 0;

   writeback_unit_if #(.ADDRESS_BITS(AB)) wb ();

   writeback_unit #(.CORE(0), .ADDRESS_BITS(AB)) dut (
      .clock  (clock),
      .reset  (reset),
      .report (report),
      .wb     (wb)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model (transaction-level) ----------------
   bit          m_init = 0;
   bit          m_busy;
   bit          m_write;
   logic [4:0]  m_wreg;
   logic [31:0] m_wdat;
   logic [31:0] m_ret;
   logic [4:0]  p_rd;
   logic [2:0]  p_f3;
   logic [31:0] p_addr;

   function automatic bit ld_value(input logic [2:0] f3, input logic [1:0] off,
                                   input logic [31:0] d, output logic [31:0] v);
      logic [31:0] sh;
      v = 32'd0;
      case (f3)
         3'd0: begin sh = d >> (8 * off); v = sh & 32'hFF; if (v[7]) v = v | 32'hFFFFFF00; return 1; end
         3'd1: begin sh = d >> (16 * off[1]); v = sh & 32'hFFFF; if (v[15]) v = v | 32'hFFFF0000; return 1; end
         3'd2: begin v = d; return 1; end
         3'd4: begin sh = d >> (8 * off); v = sh & 32'hFF; return 1; end
         3'd5: begin sh = d >> (16 * off[1]); v = sh & 32'hFFFF; return 1; end
         default: return 0;
      endcase
   endfunction

   task automatic post(input logic [4:0] r, input logic [31:0] v);
      if (r != 5'd0) begin
         m_write = 1;
         m_wreg  = r;
         m_wdat  = v;
      end
   endtask

   always @(posedge clock) begin
      logic [31:0] v;
      if (reset) begin
         m_init = 1; m_busy = 0; m_write = 0; m_wreg = 0; m_wdat = 0; m_ret = 0;
      end else if (m_init) begin
         m_write = 0;
         if (!m_busy) begin
            if (wb.valid_in) begin
               case (wb.opcode)
                  7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111: begin
                     m_ret = m_ret + 1; post(wb.rd, wb.alu_result);
                  end
                  7'b1101111, 7'b1100111: begin
                     m_ret = m_ret + 1;
                     post(wb.rd, (32'(wb.PC) + 32'd4) % (32'd1 << AB));
                  end
                  7'b0000011: begin
                     m_busy = 1; p_rd = wb.rd; p_f3 = wb.funct3; p_addr = wb.alu_result;
                  end
                  default: m_ret = m_ret + 1;
               endcase
            end
         end else if (wb.load_valid) begin
            m_busy = 0;
            m_ret  = m_ret + 1;
            if (ld_value(p_f3, p_addr[1:0], wb.load_data, v)) post(p_rd, v);
         end
      end
   end

   // one compare process, every cycle once the model has seen a reset
   always @(negedge clock) begin
      if (m_init) begin
         check("busy",       {31'd0, wb.busy},  {31'd0, m_busy});
         check("write",      {31'd0, wb.write}, {31'd0, m_write});
         check("write_reg",  {27'd0, wb.write_reg}, {27'd0, m_wreg});
         check("write_data", wb.write_data, m_wdat);
         check("retired",    wb.retired, m_ret);
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic present(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] r,
                          input logic [31:0] alu, input logic [AB-1:0] pc);
      wb.valid_in = 1'b1; wb.opcode = op; wb.funct3 = f3; wb.rd = r;
      wb.alu_result = alu; wb.PC = pc;
   endtask

   task automatic do_load(input string name, input logic [2:0] f3, input logic [31:0] alu,
                          input logic [4:0] r, input logic [31:0] d, input logic [31:0] exp);
      present(7'b0000011, f3, r, alu, '0);
      step();
      wb.valid_in = 1'b0;
      check({name, "_busy1"}, {31'd0, wb.busy}, 32'd1);
      step();
      check({name, "_busy2"}, {31'd0, wb.busy}, 32'd1);
      step();
      wb.load_valid = 1'b1; wb.load_data = d;
      check({name, "_busy3"}, {31'd0, wb.busy}, 32'd1);
      step();
      wb.load_valid = 1'b0;
      check({name, "_busy_done"}, {31'd0, wb.busy}, 32'd0);
      check({name, "_write"}, {31'd0, wb.write}, 32'd1);
      check({name, "_reg"}, {27'd0, wb.write_reg}, {27'd0, r});
      check({name, "_data"}, wb.write_data, exp);
   endtask

   initial begin
      logic [6:0] ops [10];
      ops = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b1101111,
              7'b1100111, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1110011};

      wb.valid_in = 0; wb.opcode = 0; wb.funct3 = 0; wb.rd = 0; wb.alu_result = 0;
      wb.PC = 0; wb.load_data = 0; wb.load_valid = 0;
      reset = 1;
      step(); step();
      reset = 0;
      check("rst_busy",  {31'd0, wb.busy}, 32'd0);
      check("rst_write", {31'd0, wb.write}, 32'd0);
      check("rst_reg",   {27'd0, wb.write_reg}, 32'd0);
      check("rst_data",  wb.write_data, 32'd0);
      check("rst_ret",   wb.retired, 32'd0);

      // ADDI with trace enabled
      report = 1;
      present(7'b0010011, 3'd0, 5'd5, 32'h2A, '0);
      step();
      wb.valid_in = 0;
      check("addi_write", {31'd0, wb.write}, 32'd1);
      check("addi_reg",   {27'd0, wb.write_reg}, 32'd5);
      check("addi_data",  wb.write_data, 32'h2A);
      check("addi_ret",   wb.retired, 32'd1);
      step();
      report = 0;
      check("addi_pulse", {31'd0, wb.write}, 32'd0);
      check("addi_hold",  wb.write_data, 32'h2A);

      // JAL link values, including wrap at the PC width
      present(7'b1101111, 3'd0, 5'd1, 32'h0, 20'h00100);
      step();
      wb.valid_in = 0;
      check("jal_data", wb.write_data, 32'h104);
      present(7'b1101111, 3'd0, 5'd1, 32'h0, 20'hFFFFC);
      step();
      wb.valid_in = 0;
      check("jal_wrap_write", {31'd0, wb.write}, 32'd1);
      check("jal_wrap_data", wb.write_data, 32'h0);

      // write to x0 suppressed but retired
      present(7'b0110011, 3'd0, 5'd0, 32'h1234, '0);
      step();
      wb.valid_in = 0;
      check("x0_write", {31'd0, wb.write}, 32'd0);
      check("x0_ret",   wb.retired, 32'd4);

      do_load("lb",  3'b000, 32'h3, 5'd7, 32'h80FF1234, 32'hFFFFFF80);
      do_load("lbu", 3'b100, 32'h3, 5'd7, 32'h80FF1234, 32'h00000080);
      do_load("lh",  3'b001, 32'h2, 5'd8, 32'h80FF1234, 32'hFFFF80FF);
      check("load_ret", wb.retired, 32'd7);

      // store retires without writing
      present(7'b0100011, 3'd2, 5'd4, 32'h10, '0);
      step();
      wb.valid_in = 0;
      check("store_write", {31'd0, wb.write}, 32'd0);
      check("store_ret",   wb.retired, 32'd8);

      // back-to-back: ADDI held during LOAD_WAIT
      reset = 1; step(); reset = 0;
      present(7'b0000011, 3'b010, 5'd3, 32'h0, '0);
      step();
      present(7'b0010011, 3'd0, 5'd9, 32'h55, '0);
      check("b2b_busy", {31'd0, wb.busy}, 32'd1);
      step(); step();
      wb.load_valid = 1; wb.load_data = 32'hDEADBEEF;
      step();
      wb.load_valid = 0;
      check("b2b_ld_write", {31'd0, wb.write}, 32'd1);
      check("b2b_ld_reg",   {27'd0, wb.write_reg}, 32'd3);
      check("b2b_ld_data",  wb.write_data, 32'hDEADBEEF);
      check("b2b_ld_ret",   wb.retired, 32'd1);
      check("b2b_notbusy",  {31'd0, wb.busy}, 32'd0);
      step();
      wb.valid_in = 0;
      check("b2b_addi_write", {31'd0, wb.write}, 32'd1);
      check("b2b_addi_reg",   {27'd0, wb.write_reg}, 32'd9);
      check("b2b_addi_data",  wb.write_data, 32'h55);
      check("b2b_ret",        wb.retired, 32'd2);

      // reset abandons a pending load; later load_valid in IDLE ignored
      present(7'b0000011, 3'b010, 5'd6, 32'h0, '0);
      step();
      wb.valid_in = 0;
      step();
      reset = 1; step(); reset = 0;
      wb.load_valid = 1; wb.load_data = 32'h12345678;
      step();
      wb.load_valid = 0;
      check("rstld_write", {31'd0, wb.write}, 32'd0);
      check("rstld_ret",   wb.retired, 32'd0);
      check("rstld_busy",  {31'd0, wb.busy}, 32'd0);

      // valid_in coincident with reset ignored
      present(7'b0010011, 3'd0, 5'd2, 32'h77, '0);
      reset = 1; step(); reset = 0;
      wb.valid_in = 0;
      step();
      check("rstvld_write", {31'd0, wb.write}, 32'd0);
      check("rstvld_ret",   wb.retired, 32'd0);

      // randomized phase, checked by the model every cycle
      for (int i = 0; i < 3000; i++) begin
         wb.valid_in   = ($urandom_range(0, 2) != 0);
         wb.opcode     = ($urandom_range(0, 15) == 0) ? 7'($urandom) : ops[$urandom_range(0, 9)];
         wb.funct3     = 3'($urandom);
         wb.rd         = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
         wb.alu_result = $urandom;
         wb.PC         = ($urandom_range(0, 7) == 0) ? 20'hFFFFC : 20'($urandom);
         wb.load_data  = $urandom;
         wb.load_valid = ($urandom_range(0, 3) == 0);
         reset         = ($urandom_range(0, 249) == 0);
         step();
      end
      reset = 0; wb.valid_in = 0; wb.load_valid = 0;
      step(); step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
